// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  // FSM states; encodings are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  // Opcodes handled by the control path
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Coarse ALU operation chosen by the FSM
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // ALUControl codes, held at the widest (4-bit) encoding
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct fields to ALUControl (3-bit base or 4-bit extended set).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  alu_op_e                 alu_op,
  input  logic                    op5,
  input  logic [2:0]              funct3,
  input  logic                    funct7_5,
  output logic [ALU_CTRL_W-1:0]   alu_control
);

  logic [3:0] code;

  // Select the operation; extended funct3 codes exist only in the 4-bit encoding
  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: code = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010: code = ALU_SLT;
          3'b110: code = ALU_OR;
          3'b111: code = ALU_AND;
          3'b100: if (ALU_CTRL_W == 4) code = ALU_XOR;
          3'b001: if (ALU_CTRL_W == 4) code = ALU_SLL;
          3'b101: if (ALU_CTRL_W == 4) code = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b011: if (ALU_CTRL_W == 4) code = ALU_SLTU;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    alu_control = ALU_CTRL_W'(code);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (Moore) driving datapath selects/strobes; optional MEM_WAIT_EN wait states.
// Latency: lw 5, sw/R/I/jal 4, beq/bne 3 cycles; FETCH/MEMREAD/MEMWRITE stretch while mem_ready=0 (MEM_WAIT_EN).
// Backpressure: with MEM_WAIT_EN the FSM holds its memory states until mem_ready; otherwise never stalls.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
`ifdef MEM_WAIT_EN
  input  logic                  mem_ready,
`endif
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            state
);

  state_e  state_q, state_d, cur_s;
  alu_op_e alu_op;
  logic    mem_done;
  logic    unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  // State register; reset forces FETCH on every edge it is held
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_done ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_done ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs; during reset show FETCH selects with every strobe suppressed
  always_comb begin
    cur_s     = rst ? S_FETCH : state_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    case (cur_s)
      S_FETCH: begin
        IRWrite   = mem_done;
        PCWrite   = mem_done;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        PCWrite = zero ^ funct3[0];
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  // Immediate format depends only on the opcode
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  assign state = state_q;

  mc_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (ALUControl width 3 and 4) share stimulus.
// Each instruction expands to its expected state sequence; outputs come from per-state rules.
// Random instructions, zero flag, mem_ready and mid-instruction resets follow a directed prologue.
module tb_multicycle_control_unit;

`ifdef MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif
  localparam int NCYC = 900;
  localparam int NDIR = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  logic       pcw_a, irw_a, rw_a, mw_a, adr_a;
  logic [1:0] res_a, sa_a, sb_a, imm_a;
  logic [2:0] alu_a;
  logic [3:0] st_a;
  logic       pcw_b, irw_b, rw_b, mw_b, adr_b;
  logic [1:0] res_b, sa_b, sb_b, imm_b;
  logic [3:0] alu_b;
  logic [3:0] st_b;

  multicycle_control_unit #(.ALU_CTRL_W(3)) dut_a (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a), .MemWrite(mw_a), .AdrSrc(adr_a),
    .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a),
    .ALUControl(alu_a), .state(st_a)
  );

  multicycle_control_unit #(.ALU_CTRL_W(4)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b), .MemWrite(mw_b), .AdrSrc(adr_b),
    .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b),
    .ALUControl(alu_b), .state(st_b)
  );

  typedef struct packed {
    logic       pcw, irw, rw, mw, adr;
    logic [1:0] res, sa, sb, imm;
    logic [3:0] alu;
  } ctl_t;

  // Directed prologue: lw, sw, beq(z=1), bne(z=1), R sra, addi with f7[5]=1, R sub, jal, illegal
  logic [6:0] d_op [NDIR] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1100011, 7'b0110011,
                              7'b0010011, 7'b0110011, 7'b1101111, 7'b0000000};
  logic [2:0] d_f3 [NDIR] = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [6:0] d_f7 [NDIR] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20, 7'h20, 7'h00, 7'h00};
  int         d_z  [NDIR] = '{0, 0, 2, 2, 0, 0, 0, 0, 0};

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int seq[$];
  int pos, dwell, idx, zmode;
  bit need_new, s_known, directed;
  ctl_t e3, e4, g3, g4;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_ctl(input string sfx, input ctl_t g, input ctl_t e);
    check_val({"PCWrite", sfx},   32'(g.pcw), 32'(e.pcw));
    check_val({"IRWrite", sfx},   32'(g.irw), 32'(e.irw));
    check_val({"RegWrite", sfx},  32'(g.rw),  32'(e.rw));
    check_val({"MemWrite", sfx},  32'(g.mw),  32'(e.mw));
    check_val({"AdrSrc", sfx},    32'(g.adr), 32'(e.adr));
    check_val({"ResultSrc", sfx}, 32'(g.res), 32'(e.res));
    check_val({"ALUSrcA", sfx},   32'(g.sa),  32'(e.sa));
    check_val({"ALUSrcB", sfx},   32'(g.sb),  32'(e.sb));
    check_val({"ImmSrc", sfx},    32'(g.imm), 32'(e.imm));
    check_val({"ALUControl", sfx}, 32'(g.alu), 32'(e.alu));
  endtask

  // kind: 0 add, 1 sub, 2 decode from funct fields
  function automatic logic [3:0] alu_ref(int kind, logic op5, logic [2:0] f3, logic f75, int w);
    if (kind == 1) return 4'd1;
    if (kind != 2) return 4'd0;
    case (f3)
      3'd0: return (op5 && f75) ? 4'd1 : 4'd0;
      3'd2: return 4'd5;
      3'd6: return 4'd3;
      3'd7: return 4'd2;
      default: ;
    endcase
    if (w == 4) begin
      case (f3)
        3'd4: return 4'd4;
        3'd1: return 4'd6;
        3'd5: return f75 ? 4'd8 : 4'd7;
        3'd3: return 4'd9;
        default: ;
      endcase
    end
    return 4'd0;
  endfunction

  function automatic ctl_t model(int s, logic r, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                                 logic z, logic mr, int w);
    ctl_t e;
    int   eff;
    int   kind;
    e    = '0;
    kind = 0;
    eff  = r ? 0 : s;
    case (eff)
      0:  begin e.irw = WAIT ? mr : 1'b1; e.pcw = WAIT ? mr : 1'b1; e.sb = 2; e.res = 2; end
      1:  begin e.sa = 1; e.sb = 1; end
      2:  begin e.sa = 2; e.sb = 1; end
      3:  e.adr = 1;
      4:  begin e.res = 1; e.rw = 1; end
      5:  begin e.adr = 1; e.mw = 1; end
      6:  begin e.sa = 2; kind = 2; end
      7:  e.rw = 1;
      8:  begin e.sa = 2; e.sb = 1; kind = 2; end
      9:  begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      10: begin e.sa = 2; kind = 1; e.pcw = z ^ f3[0]; end
      default: ;
    endcase
    if (r) begin e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0; end
    if (o == 7'b0100011)      e.imm = 2'b01;
    else if (o == 7'b1100011) e.imm = 2'b10;
    else if (o == 7'b1101111) e.imm = 2'b11;
    e.alu = alu_ref(kind, o[5], f3, f7[5], w);
    return e;
  endfunction

  task automatic start_instr();
    if (idx < NDIR) begin
      op = d_op[idx]; funct3 = d_f3[idx]; funct7 = d_f7[idx]; zmode = d_z[idx]; directed = 1'b1;
    end else begin
      case ($urandom_range(0, 7))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1101111;
        5, 6: op = 7'b1100011;
        default: op = 7'($urandom_range(0, 127));
      endcase
      funct3   = 3'($urandom_range(0, 7));
      funct7   = {1'b0, 1'($urandom_range(0, 1)), 5'b0};
      zmode    = 0;
      directed = 1'b0;
    end
    idx++;
    seq.delete();
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      7'b0100011: begin seq.push_back(2); seq.push_back(5); end
      7'b0110011: begin seq.push_back(6); seq.push_back(7); end
      7'b0010011: begin seq.push_back(8); seq.push_back(7); end
      7'b1101111: begin seq.push_back(9); seq.push_back(7); end
      7'b1100011: seq.push_back(10);
      default: ;
    endcase
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    pos = 0; dwell = 0; idx = 0; zmode = 0;
    need_new = 1'b1; s_known = 1'b0; directed = 1'b1;
    seq.push_back(0);
    for (cyc = 0; cyc < NCYC; cyc++) begin
      rst = (cyc < 3) || (cyc > 150 && $urandom_range(0, 59) == 0);
      if (need_new && !rst) begin
        start_instr();
        need_new = 1'b0;
      end
      zero      = (zmode == 2) ? 1'b1 : (zmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      mem_ready = directed ? (dwell >= 2) : ($urandom_range(0, 3) != 0);
      #3;
      e3 = model(seq[pos], rst, op, funct3, funct7, zero, mem_ready, 3);
      e4 = model(seq[pos], rst, op, funct3, funct7, zero, mem_ready, 4);
      g3 = {pcw_a, irw_a, rw_a, mw_a, adr_a, res_a, sa_a, sb_a, imm_a, 1'b0, alu_a};
      g4 = {pcw_b, irw_b, rw_b, mw_b, adr_b, res_b, sa_b, sb_b, imm_b, alu_b};
      if (s_known) begin
        check_val("state_w3", 32'(st_a), 32'(seq[pos]));
        check_val("state_w4", 32'(st_b), 32'(seq[pos]));
      end
      check_ctl("_w3", g3, e3);
      check_ctl("_w4", g4, e4);
      @(posedge clk);
      #1;
      if (rst) begin
        pos = 0; dwell = 0; need_new = 1'b1; s_known = 1'b1;
      end else if (WAIT && !mem_ready && (seq[pos] == 0 || seq[pos] == 3 || seq[pos] == 5)) begin
        dwell++;
      end else begin
        dwell = 0;
        pos++;
        if (pos >= seq.size()) begin
          pos = 0;
          need_new = 1'b1;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
